seq_u_div8: RTL and testbench

SEQ_U_DIV8 -- requirements
Module: seq_u_div8

---
 rtl/seq_u_div8_pkg.sv | 18 +
 rtl/seq_u_div8_rca_sub.sv | 25 ++
 rtl/seq_u_div8.sv | 116 +++++++++++
 tb/tb_seq_u_div8.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_u_div8_pkg.sv
// Shared types and constants for the sequential unsigned restoring divider.
package seq_u_div8_pkg;

  localparam int unsigned DefaultWidth    = 8;
  localparam int unsigned DefaultCntWidth = $clog2(DefaultWidth);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Iteration counter width for an arbitrary operand width (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_u_div8_rca_sub.sv
// Ripple-carry subtractor: x - y as x + ~y + 1 through a chain of full adders.
module seq_u_div8_rca_sub #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   c;
  logic [W-1:0] y_n;

  assign y_n  = ~y;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i] = x[i] ^ y_n[i] ^ c[i];
    assign c[i+1]  = (x[i] & y_n[i]) | (c[i] & (x[i] ^ y_n[i]));
  end

  // No carry out of the top stage means y > x.
  assign borrow = ~c[W];

endmodule

// File: rtl/seq_u_div8.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// Define SEQ_U_DIV8_DZ_FLAG_EN to add the dz port and a fast path for b = 0.
module seq_u_div8
  import seq_u_div8_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SEQ_U_DIV8_DZ_FLAG_EN
  output logic         dz,
`endif
  output logic [N-1:0] q,
  output logic [N-1:0] r
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q;
  logic [N-1:0]    dvd_q;
  logic [N-1:0]    div_q;
  logic [N:0]      rem_q;
  logic [N-1:0]    quot_q;
  logic [CntW-1:0] cnt_q;

  logic [N:0] trial;
  logic [N:0] diff;
  logic       borrow;

  assign trial = {rem_q[N-1:0], dvd_q[N-1]};

  seq_u_div8_rca_sub #(
    .W(N + 1)
  ) u_rca_sub (
    .x     (trial),
    .y     ({1'b0, div_q}),
    .diff  (diff),
    .borrow(borrow)
  );

`ifdef SEQ_U_DIV8_DZ_FLAG_EN
  logic dz_q;
  assign dz = dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q <= 1'b0;
    end else if (state_q == StIdle && in_valid) begin
      dz_q <= (b == '0);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            dvd_q   <= a;
            div_q   <= b;
            rem_q   <= '0;
            quot_q  <= '0;
            cnt_q   <= CntW'(N - 1);
            state_q <= StBusy;
`ifdef SEQ_U_DIV8_DZ_FLAG_EN
            if (b == '0) begin
              quot_q  <= '1;
              rem_q   <= {1'b0, a};
              state_q <= StDone;
            end
`endif
          end
        end
        StBusy: begin
          dvd_q  <= {dvd_q[N-2:0], 1'b0};
          quot_q <= {quot_q[N-2:0], ~borrow};
          rem_q  <= borrow ? trial : diff;
          if (cnt_q == '0) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The partial remainder always ends below b, so its top bit never reaches r.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[N];

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign q         = quot_q;
  assign r         = rem_q[N-1:0];

endmodule

// File: tb/tb_seq_u_div8.sv
// Self-checking bench for seq_u_div8: directed table, handshake corners, reset, random traffic.
module tb_seq_u_div8;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] q;
  logic [N-1:0] r;
`ifdef SEQ_U_DIV8_DZ_FLAG_EN
  logic         dz;
`endif

  seq_u_div8 #(
    .N(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SEQ_U_DIV8_DZ_FLAG_EN
    .dz       (dz),
`endif
    .q        (q),
    .r        (r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_sent = 0;
  int   n_recv = 0;
  bit   rnd_done = 1'b0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // Output side of the scoreboard: one pop per result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(n_recv + 1), 32'(n_sent));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q", 32'(q), 32'(e.q));
        chk("r", 32'(r), 32'(e.r));
`ifdef SEQ_U_DIV8_DZ_FLAG_EN
        chk("dz", 32'(dz), 32'(e.dz));
`endif
      end
      n_recv++;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [N-1:0] xa, input logic [N-1:0] xb,
                      input logic [N-1:0] xq, input logic [N-1:0] xr);
    exp_t e;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i > 200) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    e.q = xq;
    e.r = xr;
    e.dz = (xb == '0);
    sb.push_back(e);
    n_sent++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Garbage while busy must be ignored.
    a = N'($urandom);
    b = N'($urandom);
  endtask

  task automatic measure_latency(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(name, 32'(lat), 32'(exp_lat));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   spurious;
    int   zlat;

    vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0};
    vecs[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5};
    vecs[3] = '{a: 8'hAB,  b: 8'd0,   q: 8'hFF,  r: 8'hAB};
    vecs[4] = '{a: 8'd100, b: 8'd10,  q: 8'd10,  r: 8'd0};
    vecs[5] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0};
    vecs[6] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0};
    vecs[7] = '{a: 8'd128, b: 8'd3,   q: 8'd42,  r: 8'd2};
    vecs[8] = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1};
    vecs[9] = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Latency for a normal divide and for b = 0.
    send(8'd200, 8'd7, 8'd28, 8'd4);
    measure_latency("latency_200_7", N + 1);
    @(posedge clk);
    #1;
`ifdef SEQ_U_DIV8_DZ_FLAG_EN
    zlat = 1;
`else
    zlat = N + 1;
`endif
    send(8'hAB, 8'd0, 8'hFF, 8'hAB);
    measure_latency("latency_div0", zlat);
    drain("drain_latency");

    foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
    drain("drain_table");

    // Back-pressure: result must hold while out_ready is low.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'd200, 8'd7, 8'd28, 8'd4);
    measure_latency("latency_hold", N + 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_q", 32'(q), 32'd28);
      chk("hold_r", 32'(r), 32'd4);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the 4th busy cycle discards the operation.
    send(8'd50, 8'd3, 8'd16, 8'd2);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    sb.delete();
    n_sent--;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_r", 32'(r), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious++;
    end
    chk("no_spurious_valid", 32'(spurious), 32'd0);
    send(8'd100, 8'd10, 8'd10, 8'd0);
    drain("drain_after_reset");

    // Random traffic with input gaps and output stalls.
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          logic [N-1:0] ra;
          logic [N-1:0] rb;
          ra = N'($urandom);
          rb = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          if (rb == '0) send(ra, rb, '1, ra);
          else send(ra, rb, ra / rb, ra % rb);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");
    chk("sent_vs_received", 32'(n_recv), 32'(n_sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
